pio_bidir_irq: RTL and testbench
================================

# pio_bidir_irq

Parametrised Avalon-MM general-purpose I/O port; next generation of the NiosCpu single-register output PIO used for bit-banged I2C.
Adds:
- configurable width;
- per-bit direction;
- optional open-drain drive for I2C SCL/SDA;
- synchronised input read-back;
- atomic set/clear writes;
- edge capture with a maskable interrupt.

Sits on the Nios data master as an Avalon slave; pads/tristates stay at top level.

## Interface

- WIDTH, 8: number of I/O bits, 1..32.
- OUT_RESET, 0: reset value of output register (WIDTH bits).
- DIR_RESET, 0: reset value of direction register (1 = output).
- OPEN_DRAIN, 0: 1 = pins drive low only, release for high (I2C mode).
- EDGE_TYPE, 0: 0 rising, 1 falling, 2 any edge.
- SYNC_STAGES, 2: input synchroniser depth, 2..4.
- Clocking and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits above WIDTH ignored.
- readdata  out  32  read data, zero-extended, zero wait-state.
- pin_in  in  WIDTH  asynchronous pad inputs.
- pin_out  out  WIDTH  pad output value.
- pin_oe  out  WIDTH  pad output enable.
- irq  out  1  level interrupt to CPU.

## Operation

Register map:
- 0 DATA: read = synchronised pin_in; write = output register.
- 1 DIR: read/write direction.
- 2 IRQMASK: read/write.
- 3 EDGE: read captured edges; write 1 clears bit.
- 4 OUTSET: write 1 sets output bits; reads 0.
- 5 OUTCLR: write 1 clears output bits; reads 0.
- 6, 7: reserved, read 0, writes ignored.

Write and read decode:
- Write occurs when chipselect && !write_n.
- readdata is combinational from address and registers. It ignores chipselect and returns 0 for unused bits.

Pad drive:
- OPEN_DRAIN=0: pin_out = out_reg, pin_oe = dir.
- OPEN_DRAIN=1: pin_out = 0, pin_oe = dir & ~out_reg.

Input path and edge capture:
- pin_in passes through SYNC_STAGES flops, then one previous-sample flop for edge detection.
- An arm counter holds edge capture off until SYNC_STAGES+1 cycles after reset release. This prevents a false edge from the reset value of the synchroniser.
- EDGE bit sets on the selected edge and stays set until written 1.
- If set and write-1-clear hit the same bit in the same cycle, set wins.
- irq = |(EDGE & IRQMASK).

Reset values:
- out_reg = OUT_RESET; dir = DIR_RESET.
- IRQMASK, EDGE, synchroniser, arm counter = 0.
- Outputs follow from these: irq = 0, readdata reflects the reset registers.

Reset asserted mid-operation clears all of the above immediately, including in-flight captures.

## Timing

- Register writes take effect on the clock edge of the write; pin_out/pin_oe change in the following cycle.
- DATA read of a pin change sampled at edge n is visible after edge n+SYNC_STAGES-1.
- EDGE bit and irq assert one cycle after the change appears in DATA.
- irq drops the cycle after the clearing write or the mask write.
- Back-to-back writes every cycle are supported.
- No wait states; read latency 0.

## Structure

- Package pio_bidir_irq_pkg holds:
  - address constants ADDR_DATA..ADDR_OUTCLR;
  - edge-type constants EDGE_RISE/EDGE_FALL/EDGE_ANY;
  - localparam for the arm counter width.
- Sub-module pio_sync_edge: WIDTH-bit synchroniser, previous-sample flop, arm counter, one-cycle edge-pulse output; parametrised by WIDTH, SYNC_STAGES, EDGE_TYPE.
- Top level holds the Avalon decode, registers, pad logic and irq.

## Test plan

1. Reset with OUT_RESET=8'hA5, DIR_RESET=8'h0F.
   - Response: pin_out=A5, pin_oe=0F, irq=0, EDGE read=0.
   - Also: pin_in held 8'hFF through reset gives no EDGE bits after release.
2. Set/clear: write DATA=8'h00, OUTSET=8'h81, OUTCLR=8'h01.
   - Response: out_reg reads back 8'h80; the reserved address write leaves all registers unchanged.
3. Open-drain, OPEN_DRAIN=1, DIR=8'h03, DATA=8'h01.
   - Response: pin_oe=8'h02, pin_out=0.
   - Then DATA=8'h03 gives pin_oe=0.
4. Rising edge, EDGE_TYPE=0, IRQMASK=8'h04, pin_in bit2 0->1 at edge n.
   - Response: EDGE=8'h04 and irq=1 at edge n+SYNC_STAGES.
   - Writing EDGE=8'h04 drops irq next cycle.
   - Falling on bit2 captures nothing.
5. Simultaneous: clear-write of bit2 in the same cycle as a new bit2 edge.
   - Response: EDGE bit2 remains 1, irq stays 1.
6. Reset asserted mid-capture, with EDGE=8'hFF and IRQMASK=8'hFF.
   - Response: irq falls asynchronously, all registers return to reset values, and no edge is captured before re-arm completes.

Source files
------------

// File: rtl/pio_bidir_irq_pkg.sv
// Shared constants for the bidirectional PIO: register map, edge selection
// and the width of the post-reset arm counter.
package pio_bidir_irq_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE    = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Holds SYNC_STAGES+1 for the deepest synchroniser (4 stages -> 5).
    localparam int ARM_CNT_W = 3;

endpackage

// File: rtl/pio_sync_edge.sv
// Input synchroniser, previous-sample flop and edge detector for the PIO.
// Edge pulses are suppressed until the synchroniser has flushed its reset
// value, so pins already high at reset release do not look like edges.
module pio_sync_edge
    import pio_bidir_irq_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_pin,
    output logic [WIDTH-1:0] o_sync,
    output logic [WIDTH-1:0] o_edge
);

    localparam logic [ARM_CNT_W-1:0] ARM_DONE = ARM_CNT_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0]     r_sync [SYNC_STAGES];
    logic [WIDTH-1:0]     r_prev;
    logic [ARM_CNT_W-1:0] r_arm_cnt;
    logic                 w_armed;
    logic [WIDTH-1:0]     w_cur;
    logic [WIDTH-1:0]     w_raw;

    // Synchroniser chain followed by the previous-sample flop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_prev <= '0;
        end else begin
            r_sync[0] <= i_pin;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // Arm counter: saturates once the chain and previous flop hold real samples.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_arm_cnt <= '0;
        end else if (r_arm_cnt != ARM_DONE) begin
            r_arm_cnt <= r_arm_cnt + 1'b1;
        end
    end

    assign w_armed = (r_arm_cnt == ARM_DONE);
    assign w_cur   = r_sync[SYNC_STAGES-1];
    assign o_sync  = w_cur;

    // Select the edge polarity and gate it with the arm state.
    always_comb begin
        w_raw = '0;
        if (EDGE_TYPE == EDGE_FALL) begin
            w_raw = ~w_cur & r_prev;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            w_raw = w_cur ^ r_prev;
        end else begin
            w_raw = w_cur & ~r_prev;
        end
        o_edge = w_armed ? w_raw : '0;
    end

endmodule

// File: rtl/pio_bidir_irq.sv
// Avalon-MM general-purpose I/O port with per-bit direction, optional
// open-drain drive, atomic set/clear writes and maskable edge interrupts.
module pio_bidir_irq
    import pio_bidir_irq_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] OUT_RESET   = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '0,
    parameter bit               OPEN_DRAIN  = 1'b0,
    parameter int               EDGE_TYPE   = EDGE_RISE,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_out,
    output logic [WIDTH-1:0] pin_oe,
    output logic             irq
);

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_edge;
    logic             w_wr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_edge_pulse;
    logic [WIDTH-1:0] w_edge_clr;

    assign w_wr    = chipselect & ~write_n;
    assign w_wdata = writedata[WIDTH-1:0];

    generate
        if (WIDTH < 32) begin : g_unused_wdata
            logic w_unused_wdata;
            assign w_unused_wdata = ^writedata[31:WIDTH];
        end
    endgenerate

    pio_sync_edge #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC_STAGES),
        .EDGE_TYPE  (EDGE_TYPE)
    ) u_sync_edge (
        .i_clk (clk),
        .i_rst (reset),
        .i_pin (pin_in),
        .o_sync(w_sync),
        .o_edge(w_edge_pulse)
    );

    // Output, direction and mask registers with atomic set/clear on the output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out  <= OUT_RESET;
            r_dir  <= DIR_RESET;
            r_mask <= '0;
        end else if (w_wr) begin
            case (address)
                ADDR_DATA:    r_out  <= w_wdata;
                ADDR_OUTSET:  r_out  <= r_out | w_wdata;
                ADDR_OUTCLR:  r_out  <= r_out & ~w_wdata;
                ADDR_DIR:     r_dir  <= w_wdata;
                ADDR_IRQMASK: r_mask <= w_wdata;
                default: ;
            endcase
        end
    end

    assign w_edge_clr = (w_wr && address == ADDR_EDGE) ? w_wdata : '0;

    // Edge capture: a new edge beats a write-1-clear of the same bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_edge <= '0;
        end else begin
            r_edge <= (r_edge & ~w_edge_clr) | w_edge_pulse;
        end
    end

    // Zero wait-state read mux, zero-extended, independent of chipselect.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[WIDTH-1:0] = w_sync;
            ADDR_DIR:     readdata[WIDTH-1:0] = r_dir;
            ADDR_IRQMASK: readdata[WIDTH-1:0] = r_mask;
            ADDR_EDGE:    readdata[WIDTH-1:0] = r_edge;
            default: ;
        endcase
    end

    // Pad drive: open-drain only pulls low, and releases the pin for a 1.
    generate
        if (OPEN_DRAIN) begin : g_od
            assign pin_out = '0;
            assign pin_oe  = r_dir & ~r_out;
        end else begin : g_pp
            assign pin_out = r_out;
            assign pin_oe  = r_dir;
        end
    endgenerate

    assign irq = |(r_edge & r_mask);

endmodule

// File: tb/tb_pio_bidir_irq.sv
// Bench for pio_bidir_irq: two instances on a shared bus (push-pull/rising/
// 2-stage and open-drain/falling/3-stage) checked every cycle against a
// history-based model, plus literal expectations for the directed scenarios.
module tb_pio_bidir_irq;

    localparam logic [7:0] P_OUT_RST = 8'hA5;
    localparam logic [7:0] P_DIR_RST = 8'h0F;

    logic        clk;
    logic        reset = 1'b1;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  pin_in;

    logic [31:0] rd0, rd1;
    logic [7:0]  po0, po1, oe0, oe1;
    logic        irq0, irq1;

    int n_checks = 0;
    int n_fail   = 0;

    pio_bidir_irq #(
        .WIDTH(8), .OUT_RESET(P_OUT_RST), .DIR_RESET(P_DIR_RST),
        .OPEN_DRAIN(1'b0), .EDGE_TYPE(0), .SYNC_STAGES(2)
    ) u_dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd0),
        .pin_in(pin_in), .pin_out(po0), .pin_oe(oe0), .irq(irq0)
    );

    pio_bidir_irq #(
        .WIDTH(8), .OUT_RESET(P_OUT_RST), .DIR_RESET(P_DIR_RST),
        .OPEN_DRAIN(1'b1), .EDGE_TYPE(1), .SYNC_STAGES(3)
    ) u_od (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd1),
        .pin_in(pin_in), .pin_out(po1), .pin_oe(oe1), .irq(irq1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- model ----------------
    // Per instance: register values plus a history of pin samples taken at
    // each clock edge since reset (index 0 = most recent). DATA shows the
    // sample from SYNC_STAGES-1 edges ago; an edge is the change between the
    // two samples before that, ignored until SYNC_STAGES+1 edges after reset.
    logic [7:0] m_out  [2];
    logic [7:0] m_dir  [2];
    logic [7:0] m_mask [2];
    logic [7:0] m_edge [2];
    logic [7:0] m_hist [2][8];
    int         m_cyc  [2];

    function automatic int m_s(int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic logic [7:0] m_events(int i);
        logic [7:0] cur, old, ev;
        cur = m_hist[i][m_s(i)-1];
        old = m_hist[i][m_s(i)];
        if (i == 0) ev = cur & ~old;
        else        ev = ~cur & old;
        if (m_cyc[i] < m_s(i) + 1) ev = 8'h00;
        return ev;
    endfunction

    function automatic logic [31:0] m_rd(int i);
        logic [7:0] v;
        v = 8'h00;
        case (address)
            3'd0: v = m_hist[i][m_s(i)-1];
            3'd1: v = m_dir[i];
            3'd2: v = m_mask[i];
            3'd3: v = m_edge[i];
            default: v = 8'h00;
        endcase
        return {24'h0, v};
    endfunction

    task automatic model_step();
        logic       wr;
        logic [7:0] wd, ev, clr;
        wr = chipselect && !write_n;
        wd = writedata[7:0];
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                for (int j = 0; j < 8; j++) m_hist[i][j] = 8'h00;
                m_out[i]  = P_OUT_RST;
                m_dir[i]  = P_DIR_RST;
                m_mask[i] = 8'h00;
                m_edge[i] = 8'h00;
                m_cyc[i]  = 0;
            end else begin
                ev  = m_events(i);
                clr = (wr && address == 3'd3) ? wd : 8'h00;
                m_edge[i] = (m_edge[i] & ~clr) | ev;
                if (wr) begin
                    case (address)
                        3'd0: m_out[i]  = wd;
                        3'd1: m_dir[i]  = wd;
                        3'd2: m_mask[i] = wd;
                        3'd4: m_out[i]  = m_out[i] | wd;
                        3'd5: m_out[i]  = m_out[i] & ~wd;
                        default: ;
                    endcase
                end
                for (int j = 7; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
                m_hist[i][0] = pin_in;
                if (m_cyc[i] < 100) m_cyc[i]++;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            model_step();
        end
    end

    // ---------------- checking ----------------
    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            cmp("pp_readdata", rd0, m_rd(0));
            cmp("pp_pin_out", {24'h0, po0}, {24'h0, m_out[0]});
            cmp("pp_pin_oe", {24'h0, oe0}, {24'h0, m_dir[0]});
            cmp("pp_irq", {31'h0, irq0}, {31'h0, |(m_edge[0] & m_mask[0])});
            cmp("od_readdata", rd1, m_rd(1));
            cmp("od_pin_out", {24'h0, po1}, 32'h0);
            cmp("od_pin_oe", {24'h0, oe1}, {24'h0, m_dir[1] & ~m_out[1]});
            cmp("od_irq", {31'h0, irq1}, {31'h0, |(m_edge[1] & m_mask[1])});
        end
    end

    // ---------------- stimulus ----------------
    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        address    = a;
        writedata  = {24'hDEAD_BE, d};
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd_chk(input string nm, input logic [2:0] a, input logic [31:0] exp);
        address = a;
        #1;
        cmp(nm, rd0, exp);
    endtask

    initial begin
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 32'h0;
        pin_in     = 8'hFF;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // 1: reset values; pins high through reset produce no edges
        repeat (6) @(negedge clk);
        #1;
        cmp("t1_pin_out", {24'h0, po0}, 32'hA5);
        cmp("t1_pin_oe", {24'h0, oe0}, 32'h0F);
        cmp("t1_irq", {31'h0, irq0}, 32'h0);
        cmp("t1_od_pin_oe", {24'h0, oe1}, 32'h0A);
        rd_chk("t1_edge", 3'd3, 32'h0);
        rd_chk("t1_data", 3'd0, 32'hFF);

        // 2: set/clear and reserved addresses
        @(negedge clk);
        wr(3'd0, 8'h00);
        wr(3'd4, 8'h81);
        wr(3'd5, 8'h01);
        #1 cmp("t2_out_reg", {24'h0, po0}, 32'h80);
        wr(3'd6, 8'hFF);
        wr(3'd7, 8'hFF);
        #1 cmp("t2_rsvd_out", {24'h0, po0}, 32'h80);
        rd_chk("t2_rsvd_dir", 3'd1, 32'h0F);
        rd_chk("t2_rsvd_mask", 3'd2, 32'h0);
        rd_chk("t2_read_outset", 3'd4, 32'h0);
        rd_chk("t2_read_rsvd", 3'd6, 32'h0);

        // 3: open-drain drive
        @(negedge clk);
        wr(3'd1, 8'h03);
        wr(3'd0, 8'h01);
        #1;
        cmp("t3_od_oe", {24'h0, oe1}, 32'h02);
        cmp("t3_od_out", {24'h0, po1}, 32'h0);
        wr(3'd0, 8'h03);
        #1 cmp("t3_od_oe_rel", {24'h0, oe1}, 32'h0);

        // 4: rising edge on bit2, clear, then falling captures nothing
        @(negedge clk);
        pin_in = 8'h00;
        repeat (6) @(negedge clk);
        wr(3'd2, 8'h04);
        address = 3'd3;
        pin_in  = 8'h04;
        @(posedge clk);
        @(posedge clk);
        #1 cmp("t4_irq_early", {31'h0, irq0}, 32'h0);
        @(posedge clk);
        #1;
        cmp("t4_irq", {31'h0, irq0}, 32'h1);
        cmp("t4_edge", rd0, 32'h04);
        @(negedge clk);
        wr(3'd3, 8'h04);
        #1 cmp("t4_irq_clr", {31'h0, irq0}, 32'h0);
        pin_in = 8'h00;
        repeat (6) @(negedge clk);
        rd_chk("t4_fall_edge", 3'd3, 32'h0);

        // 5: clear-write lands on the same edge as a new capture
        pin_in = 8'h04;
        repeat (4) @(negedge clk);
        #1 cmp("t5_pre_irq", {31'h0, irq0}, 32'h1);
        pin_in = 8'h00;
        repeat (4) @(negedge clk);
        pin_in = 8'h04;
        @(negedge clk);
        @(negedge clk);
        wr(3'd3, 8'h04);
        #1;
        cmp("t5_edge_kept", rd0, 32'h04);
        cmp("t5_irq_kept", {31'h0, irq0}, 32'h1);

        // 6: reset in the middle of capture activity
        wr(3'd3, 8'hFF);
        pin_in = 8'h00;
        repeat (6) @(negedge clk);
        wr(3'd2, 8'hFF);
        pin_in = 8'hFF;
        repeat (5) @(negedge clk);
        rd_chk("t6_edge_all", 3'd3, 32'hFF);
        cmp("t6_irq_on", {31'h0, irq0}, 32'h1);
        pin_in = 8'h00;
        @(negedge clk);
        pin_in = 8'hFF;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        cmp("t6_irq_async", {31'h0, irq0}, 32'h0);
        cmp("t6_od_irq_async", {31'h0, irq1}, 32'h0);
        cmp("t6_pin_out_rst", {24'h0, po0}, 32'hA5);
        cmp("t6_pin_oe_rst", {24'h0, oe0}, 32'h0F);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        rd_chk("t6_edge_rearm", 3'd3, 32'h0);
        cmp("t6_irq_rearm", {31'h0, irq0}, 32'h0);
        rd_chk("t6_mask_rst", 3'd2, 32'h0);
        rd_chk("t6_dir_rst", 3'd1, 32'h0F);
        rd_chk("t6_data", 3'd0, 32'hFF);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
